// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between Fetch and a loader/debug port.
// Fetch owns the port by default; loader grants stall Fetch, bounded by a burst limit unless halted.
module imem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_stall,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_halt,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              cpu_halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_YIELD = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_ld_gnt;
    logic             w_fetch_stall;
    logic             r_fetch_valid;
    logic             r_ld_rvalid;
    logic             r_cpu_halted;

    // Grant is gated by rst so a write presented during reset never reaches the RAM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_ld_gnt = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_RUN, S_LOAD: w_ld_gnt = ld_req && (r_burst_cnt < MAX_CNT);
                S_HALT:        w_ld_gnt = ld_req;
                default:       w_ld_gnt = 1'b0;
            endcase
        end
    end

    assign w_fetch_stall = rst | w_ld_gnt | (r_state == S_HALT);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_burst_cnt;
        if (ld_halt) begin
            w_next_state = S_HALT;
            w_next_cnt   = '0;
        end else begin
            unique case (r_state)
                S_HALT: begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end
                S_RUN: begin
                    if (w_ld_gnt) begin
                        w_next_state = S_LOAD;
                        w_next_cnt   = CNT_W'(1);
                    end else begin
                        w_next_cnt   = '0;
                    end
                end
                S_LOAD: begin
                    if (w_ld_gnt) begin
                        w_next_cnt = (r_burst_cnt == MAX_CNT) ? r_burst_cnt : r_burst_cnt + 1'b1;
                    end else if (!ld_req) begin
                        w_next_state = S_RUN;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = S_YIELD;
                    end
                end
                S_YIELD: begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end
                default: begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_burst_cnt   <= '0;
            r_fetch_valid <= 1'b0;
            r_ld_rvalid   <= 1'b0;
            r_cpu_halted  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
            r_state       <= w_next_state;
            r_burst_cnt   <= w_next_cnt;
            r_fetch_valid <= !w_fetch_stall;
            r_ld_rvalid   <= w_ld_gnt & !ld_we;
            r_cpu_halted  <= (w_next_state == S_HALT);
        end
    end

    // The RAM read data fans out to both requesters; the valid flags say whose it is.
    assign mem_addr    = w_ld_gnt ? ld_addr : fetch_addr;
    assign mem_we      = w_ld_gnt & ld_we;
    assign mem_wdata   = ld_wdata;
    assign ld_gnt      = w_ld_gnt;
    assign fetch_stall = w_fetch_stall;
    assign fetch_data  = mem_rdata;
    assign ld_rdata    = mem_rdata;
    assign fetch_valid = r_fetch_valid;
    assign ld_rvalid   = r_ld_rvalid;
    assign cpu_halted  = r_cpu_halted;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random traffic against a behavioural model
// of the arbitration rules and a reference copy of the instruction memory.
module tb_imem_arbiter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_stall;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              ld_req = 1'b0;
    logic              ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_wdata = '0;
    logic              ld_halt = 1'b0;
    logic              ld_gnt;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_rvalid;
    logic              cpu_halted;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_halt(ld_halt), .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .cpu_halted(cpu_halted),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read returns the pre-write contents.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                m_halted;
    int                m_streak;
    bit                m_cool;
    bit                e_fv, e_rv, e_halt;
    logic [DATA_W-1:0] e_ldata, e_fdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0;
        m_streak = 0;
        m_cool   = 1'b0;
        e_fv     = 1'b0;
        e_rv     = 1'b0;
        e_halt   = 1'b0;
    endtask

    // One clock of stimulus; returns whether the model predicts a loader grant.
    task automatic step(input bit req, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input bit halt,
                        input logic [ADDR_W-1:0] fa, output bit gnt);
        bit stall;
        @(negedge clk);
        rst = 1'b0; ld_req = req; ld_we = we; ld_addr = addr; ld_wdata = wd;
        ld_halt = halt; fetch_addr = fa;
        #1;
        if (m_halted)    gnt = req;
        else if (m_cool) gnt = 1'b0;
        else             gnt = req && (m_streak < MAX_BURST);
        stall = gnt || m_halted;

        check("ld_gnt", 64'(ld_gnt), 64'(gnt));
        check("fetch_stall", 64'(fetch_stall), 64'(stall));
        check("mem_we", 64'(mem_we), 64'(gnt && we));
        check("mem_addr", 64'(mem_addr), 64'(gnt ? addr : fa));
        if (gnt && we) check("mem_wdata", 64'(mem_wdata), 64'(wd));
        check("fetch_valid", 64'(fetch_valid), 64'(e_fv));
        check("ld_rvalid", 64'(ld_rvalid), 64'(e_rv));
        check("cpu_halted", 64'(cpu_halted), 64'(e_halt));
        if (e_rv) check("ld_rdata", 64'(ld_rdata), 64'(e_ldata));
        if (e_fv) check("fetch_data", 64'(fetch_data), 64'(e_fdata));

        e_fv    = !stall;
        e_rv    = gnt && !we;
        e_ldata = ref_mem[addr];
        e_fdata = ref_mem[fa];
        if (gnt && we) ref_mem[addr] = wd;

        // Behavioural rules: halt wins; a full streak with a pending request costs
        // the loader the refused cycle plus one guaranteed Fetch cycle.
        if (halt) begin
            m_halted = 1'b1; m_streak = 0; m_cool = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b0; m_streak = 0;
        end else if (m_cool) begin
            m_cool = 1'b0; m_streak = 0;
        end else if (gnt) begin
            m_streak++;
        end else if (!req) begin
            m_streak = 0;
        end else begin
            m_cool = 1'b1; m_streak = 0;
        end
        e_halt = m_halted;
    endtask

    // Asserts reset mid-cycle with a loader write presented; it must not reach the RAM.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_halt = 1'b0;
        #1;
        check("rst_ld_gnt", 64'(ld_gnt), 64'd0);
        check("rst_fetch_stall", 64'(fetch_stall), 64'd1);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_ld_rvalid", 64'(ld_rvalid), 64'd0);
        check("rst_cpu_halted", 64'(cpu_halted), 64'd0);
        @(posedge clk);
        #1;
        check("rst_mem_we_edge", 64'(mem_we), 64'd0);
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        int k;
        bit halt_r;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        model_reset();
        apply_reset();

        // Idle fetch stream
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0, ADDR_W'(i * 4), g);
        check("idle_fetch_valid", 64'(fetch_valid), 64'd1);

        // Single loader read
        step(1, 0, 10'h010, '0, 0, 10'h010, g);
        step(0, 0, '0, '0, 0, 10'h014, g);
        check("single_rd_rvalid", 64'(ld_rvalid), 64'd1);
        check("single_rd_fvalid", 64'(fetch_valid), 64'd0);

        // Sustained loader requests exercise the burst limit
        for (int i = 0; i < 10; i++) step(1, 0, ADDR_W'($urandom), '0, 0, 10'h020, g);
        step(0, 0, '0, '0, 0, 10'h024, g);

        // Halt and bulk load 16 words, then resume
        step(0, 0, '0, '0, 1, 10'h028, g);
        for (int i = 0; i < 16; i++) step(1, 1, ADDR_W'(i * 4), $urandom, 1, 10'h028, g);
        step(0, 0, '0, '0, 0, 10'h028, g);
        step(0, 0, '0, '0, 0, 10'h028, g);
        check("resume_stall", 64'(fetch_stall), 64'd0);
        for (int i = 0; i < 16; i++) begin
            k = 0;
            do begin
                step(1, 0, ADDR_W'(i * 4), '0, 0, 10'h02c, g);
                k++;
            end while (!g && k < 4);
            check("readback_grant", 64'(g), 64'd1);
        end
        step(0, 0, '0, '0, 0, 10'h030, g);

        // Reset in the middle of a burst with a read in flight
        step(1, 0, 10'h100, '0, 0, 10'h034, g);
        step(1, 0, 10'h104, '0, 0, 10'h034, g);
        apply_reset();
        for (int i = 0; i < 6; i++) step(1, 0, ADDR_W'(i), '0, 0, 10'h038, g);

        // Random traffic
        halt_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) halt_r = !halt_r;
            step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, ADDR_W'($urandom),
                 $urandom, halt_r, ADDR_W'($urandom), g);
        end
        step(0, 0, '0, '0, 0, '0, g);
        step(0, 0, '0, '0, 0, '0, g);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
